// File: rtl/fast_bconv_if.sv
// Conversion bus for fast_bconv_single: one input RNS integer in, one converted
// RNS integer out, each qualified by a valid bit.
interface fast_bconv_if #(
    parameter int RESIDUE_W = 32,
    parameter int IN_LEN    = 3,
    parameter int OUT_LEN   = 2
);
    logic                               in_valid;
    logic [IN_LEN-1:0][RESIDUE_W-1:0]   input_RNSint;
    logic                               out_valid;
    logic [OUT_LEN-1:0][RESIDUE_W-1:0]  output_RNSint;

    modport master (
        output in_valid,
        output input_RNSint,
        input  out_valid,
        input  output_RNSint
    );

    modport slave (
        input  in_valid,
        input  input_RNSint,
        output out_valid,
        output output_RNSint
    );
endinterface

// File: rtl/fast_bconv_single.sv
// Fast-BConv of one RNS coefficient from basis {q_i} to basis {b_j}.
// Three register stages: a_i = x_i*z_i mod q_i, p_ji = a_i*y_ij mod b_j, c_j = sum_i p_ji mod b_j.
module fast_bconv_single #(
    parameter int RESIDUE_W     = 32,
    parameter int IN_BASIS_LEN  = 3,
    parameter int OUT_BASIS_LEN = 2,
    parameter logic [RESIDUE_W-1:0] IN_BASIS [IN_BASIS_LEN] = '{5, 7, 11},
    parameter logic [RESIDUE_W-1:0] OUT_BASIS [OUT_BASIS_LEN] = '{13, 17},
    parameter logic [RESIDUE_W-1:0] ZiLUT [IN_BASIS_LEN] = '{3, 6, 6},
    parameter logic [RESIDUE_W-1:0] YMODB [OUT_BASIS_LEN][IN_BASIS_LEN] = '{'{12, 3, 9}, '{9, 4, 1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    fast_bconv_if.slave  bus
);
    typedef logic [RESIDUE_W-1:0]   rns_residue_t;
    typedef logic [2*RESIDUE_W-1:0] wide_t;

    // Sum of IN_BASIS_LEN residues each below b_j, plus one bit of margin.
    localparam int SUM_W = RESIDUE_W + $clog2(IN_BASIS_LEN) + 1;
    typedef logic [SUM_W-1:0] sum_t;

    // Product is formed at double width so the % sees the exact value.
    function automatic rns_residue_t mul_mod(rns_residue_t a, rns_residue_t b, rns_residue_t m);
        wide_t prod;
        prod = wide_t'(a) * wide_t'(b);
        return rns_residue_t'(prod % wide_t'(m));
    endfunction

    rns_residue_t s1_a_next [IN_BASIS_LEN];
    rns_residue_t s1_a      [IN_BASIS_LEN];
    logic         s1_valid;

    rns_residue_t s2_p_next [OUT_BASIS_LEN][IN_BASIS_LEN];
    rns_residue_t s2_p      [OUT_BASIS_LEN][IN_BASIS_LEN];
    logic         s2_valid;

    sum_t         s3_sum    [OUT_BASIS_LEN];
    rns_residue_t s3_c_next [OUT_BASIS_LEN];

    logic                                    out_valid_q;
    logic [OUT_BASIS_LEN-1:0][RESIDUE_W-1:0] out_data_q;

    always_comb begin
        for (int i = 0; i < IN_BASIS_LEN; i++) begin
            s1_a_next[i] = mul_mod(bus.input_RNSint[i], ZiLUT[i], IN_BASIS[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_BASIS_LEN; j++) begin
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                s2_p_next[j][i] = mul_mod(s1_a[i], YMODB[j][i], OUT_BASIS[j]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_BASIS_LEN; j++) begin
            s3_sum[j] = '0;
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                s3_sum[j] = s3_sum[j] + sum_t'(s2_p[j][i]);
            end
            s3_c_next[j] = rns_residue_t'(s3_sum[j] % sum_t'(OUT_BASIS[j]));
        end
    end

    // NOTE: state is written with <= so every stage samples the previous
    // stage's value from before the edge, which is what makes this a pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: data registers are cleared too, because a visible result
            // must read as 0 after reset rather than the last pre-reset value.
            out_data_q  <= '0;
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                s1_a[i] <= '0;
            end
            for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                for (int i = 0; i < IN_BASIS_LEN; i++) begin
                    s2_p[j][i] <= '0;
                end
            end
        end else begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            if (bus.in_valid) begin
                s1_a <= s1_a_next;
            end
            if (s1_valid) begin
                s2_p <= s2_p_next;
            end
            // Bubbles never touch the output, so it holds the last real result.
            if (s2_valid) begin
                for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                    out_data_q[j] <= s3_c_next[j];
                end
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.output_RNSint = out_data_q;
endmodule

// File: tb/tb_fast_bconv_single.sv
// Bench for fast_bconv_single: directed and random conversions checked through a
// scoreboard against a CRT-style reference value V = sum_i a_i*(q/q_i).
module tb_fast_bconv_single;
    localparam int W  = 32;
    localparam int NI = 3;
    localparam int NO = 2;
    localparam int Q [NI] = '{5, 7, 11};
    localparam int B [NO] = '{13, 17};
    localparam int Z [NI] = '{3, 6, 6};
    localparam longint QPROD = 385;
    localparam int LATENCY = 3;

    typedef logic [NI-1:0][W-1:0] in_vec_t;
    typedef logic [NO-1:0][W-1:0] out_vec_t;
    typedef struct packed {
        out_vec_t c;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb [$];
    out_vec_t last_out = '0;

    fast_bconv_if #(.RESIDUE_W(W), .IN_LEN(NI), .OUT_LEN(NO)) bus ();

    fast_bconv_single #(
        .RESIDUE_W(W),
        .IN_BASIS_LEN(NI),
        .OUT_BASIS_LEN(NO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the base-q combination of a_i is an integer x + e*q, reduce it per b_j.
    function automatic out_vec_t model(input in_vec_t x);
        longint   v;
        longint   a;
        out_vec_t c;
        v = 0;
        for (int i = 0; i < NI; i++) begin
            a = ((longint'(x[i]) % Q[i]) * Z[i]) % Q[i];
            v += a * (QPROD / Q[i]);
        end
        for (int j = 0; j < NO; j++) begin
            c[j] = W'(v % B[j]);
        end
        return c;
    endfunction

    function automatic in_vec_t residues(input longint x);
        in_vec_t r;
        for (int i = 0; i < NI; i++) begin
            r[i] = W'(x % Q[i]);
        end
        return r;
    endfunction

    function automatic out_vec_t pk(input int c0, input int c1);
        out_vec_t c;
        c[0] = W'(c0);
        c[1] = W'(c1);
        return c;
    endfunction

    // Called #1 after a rising edge; the next edge samples the input.
    task automatic send(input in_vec_t x, input out_vec_t expv);
        exp_t e;
        e.c   = expv;
        e.cyc = cyc;
        bus.in_valid     = 1'b1;
        bus.input_RNSint = x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out c0", bus.output_RNSint[0], e.c[0]);
                    check("out c1", bus.output_RNSint[1], e.c[1]);
                    check("latency", cyc - e.cyc, LATENCY);
                    check("c0 below b0", longint'(bus.output_RNSint[0] < W'(B[0])), 1);
                    last_out = bus.output_RNSint;
                end
            end else begin
                check("hold c0", bus.output_RNSint[0], last_out[0]);
                check("hold c1", bus.output_RNSint[1], last_out[1]);
            end
        end
    end

    initial begin
        in_vec_t x;
        int      waited;
        bus.in_valid     = 1'b0;
        bus.input_RNSint = '0;
        #12;
        check("reset out_valid", bus.out_valid, 0);
        check("reset output", bus.output_RNSint, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        send(residues(1), pk(4, 6));
        idle(3);
        send(residues(2), pk(10, 13));
        send(residues(0), pk(0, 0));
        send(residues(384), pk(7, 10));
        idle(4);

        // Back-to-back, then isolated single-cycle pulses.
        send(residues(1), pk(4, 6));
        send(residues(2), pk(10, 13));
        idle(2);
        send(residues(384), pk(7, 10));
        idle(3);
        send(residues(1), pk(4, 6));
        idle(5);

        // Reset with a conversion in flight: it must vanish without a pulse.
        send(residues(1), pk(4, 6));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async reset out_valid", bus.out_valid, 0);
        check("async reset output", bus.output_RNSint, 0);
        last_out = '0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        send(residues(2), pk(10, 13));
        idle(4);

        for (int k = 0; k < 100; k++) begin
            x = residues(longint'($urandom));
            send(x, model(x));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        // Unreduced residues exercise the true-modulo path.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NI; i++) begin
                x[i] = $urandom;
            end
            send(x, model(x));
        end

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        check("scoreboard drained", sb.size(), 0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fast_bconv_single.md
Name: fast_bconv_single

Overview:
- Fast base conversion (Fast-BConv) of one RNS integer from input basis {q_i} to output basis {b_j}, as used in CKKS/BFV key-switching and rescale datapaths.
- Computes a_i = (x_i·z_i) mod q_i, then c_j = (Σ_i a_i·y_ij) mod b_j.
- Result equals x + e·q (0 ≤ e < IN_BASIS_LEN) reduced mod each b_j.
- Single-coefficient, fully pipelined, one conversion accepted per cycle.

Parameters:
- IN_BASIS_LEN, 3, number of input moduli q_i.
- OUT_BASIS_LEN, 2, number of output moduli b_j.
- IN_BASIS, '{5,7,11}, rns_residue_t array [IN_BASIS_LEN] of moduli q_i.
- OUT_BASIS, '{13,17}, rns_residue_t array [OUT_BASIS_LEN] of moduli b_j.
- ZiLUT, '{3,6,6}, rns_residue_t array [IN_BASIS_LEN]: z_i = (q/q_i)^-1 mod q_i.
- YMODB, '{'{12,3,9},'{9,4,1}}, rns_residue_t array [OUT_BASIS_LEN][IN_BASIS_LEN]: y_ij = (q/q_i) mod b_j (row j, column i).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input_RNSint is valid this cycle.
- input_RNSint, input, rns_residue_t [IN_BASIS_LEN], residues x_i of the input value.
- out_valid, output, 1, one-cycle pulse: output_RNSint carries a new result.
- output_RNSint, output, rns_residue_t [OUT_BASIS_LEN], converted residues c_j.

Behaviour:
- Interface: one clock (clk), asynchronous active-low reset (rst_n).
- Reset (rst_n=0, asynchronous): all pipeline valid bits, out_valid, output_RNSint and internal data registers clear to 0 immediately. Pipeline in flight at reset is discarded and no out_valid is produced for it.
- Input is sampled on a rising clk edge when in_valid=1 and rst_n=1. No backpressure and no ready signal; a new input is accepted every cycle.
- Stage 1 registers a_i = (x_i·ZiLUT[i]) mod IN_BASIS[i] for all i.
- Stage 2 registers p_ji = (a_i·YMODB[j][i]) mod OUT_BASIS[j] for all i,j.
- Stage 3 registers c_j = (Σ_i p_ji) mod OUT_BASIS[j] into output_RNSint. The adder tree is wide enough for IN_BASIS_LEN·max(b_j), then reduced.
- Latency: exactly 3 rising edges from the sampling edge to the edge that asserts out_valid together with the result.
- A valid bit travels with the data. out_valid is high for exactly one cycle per accepted input. Back-to-back inputs give back-to-back out_valid pulses in order.
- output_RNSint holds its last result while out_valid=0. It updates only on valid results.
- Arithmetic:
  - Multiplications use a double-width (2×rns_residue_t) intermediate before the % reduction.
  - Reduction is a true modulo, so inputs x_i ≥ q_i still give (x_i mod q_i)-consistent results.
  - All outputs are < OUT_BASIS[j].
- All LUT contents are elaboration-time constants; no runtime programming.
- in_valid=0 cycles insert bubbles; data registers on invalid stages may hold any value but must not reach output_RNSint.

Test Plan:
- x=1 → residues {1,1,1} → a={3,6,6} → output {4,6}, out_valid high 3 cycles after sampling.
- x=2 → residues {2,2,2} → output {10,13}. x=0 → residues {0,0,0} → output {0,0}.
- x=384 (q−1) → residues {4,6,10} → output {7,10}.
- Back-to-back: x=1 then x=2 on consecutive cycles → out_valid high 2 consecutive cycles with {4,6} then {10,13}. Single-cycle in_valid pulses separated by gaps → exactly one out_valid pulse each.
- Reset mid-operation: accept x=1, drop rst_n one cycle later → out_valid and outputs go 0 asynchronously, no pulse after release. Then x=2 → {10,13}.
- 100 random 32-bit x, residues taken mod {5,7,11} → every output matches the golden formula (Σ((x_i·z_i mod q_i)·y_ij mod b_j)) mod b_j.
